// File: rtl/mic_sample_capture.sv
// Pmod MIC3 (ADCS7476-style) capture front end: one 16-SCLK conversion per
// sample period, 12-bit result plus 10-bit wave_sample and a sample-rate clock.
module mic_sample_capture #(
   parameter int unsigned SCLK_HALF  = 50,
   parameter int unsigned SAMPLE_DIV = 5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        J_MIC_MISO,
   output logic        J_MIC_SCLK,
   output logic        J_MIC_CS_N,
   output logic [11:0] raw_sample,
   output logic [9:0]  wave_sample,
   output logic        sample_valid,
   output logic        clk_sample
);

   localparam int unsigned SCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned HCW = $clog2(SCLK_HALF + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

   state_t            state, state_nx;
   logic [SCW-1:0]    scnt, scnt_nx;
   logic [HCW-1:0]    hcnt, hcnt_nx;
   logic [4:0]        bit_cnt, bit_cnt_nx;
   logic [15:0]       shift, shift_nx;
   logic              cs_n_nx, sclk_nx, valid_nx;
   logic [11:0]       raw_nx;
   logic [9:0]        wave_nx;
   logic              half_end;

   // Sample-period counter free-runs regardless of conversion progress.
   always_comb begin
      scnt_nx = scnt + SCW'(1);
      if (scnt == SCW'(SAMPLE_DIV - 1)) scnt_nx = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt       <= '0;
         clk_sample <= 1'b0;
      end else begin
         scnt       <= scnt_nx;
         clk_sample <= (scnt_nx >= SCW'(SAMPLE_DIV / 2));
      end
   end

   assign half_end = (hcnt == HCW'(SCLK_HALF - 1));

   always_comb begin
      state_nx   = state;
      hcnt_nx    = hcnt;
      bit_cnt_nx = bit_cnt;
      shift_nx   = shift;
      cs_n_nx    = J_MIC_CS_N;
      sclk_nx    = J_MIC_SCLK;
      valid_nx   = 1'b0;
      raw_nx     = raw_sample;
      wave_nx    = wave_sample;
      unique case (state)
         IDLE: begin
            cs_n_nx = 1'b1;
            sclk_nx = 1'b1;
            if (scnt == '0) begin
               state_nx = SETUP;
               cs_n_nx  = 1'b0;
               hcnt_nx  = '0;
            end
         end
         SETUP: begin
            if (half_end) begin
               state_nx   = SHIFT;
               sclk_nx    = 1'b0;
               hcnt_nx    = '0;
               bit_cnt_nx = '0;
            end else begin
               hcnt_nx = hcnt + HCW'(1);
            end
         end
         SHIFT: begin
            if (half_end) begin
               hcnt_nx = '0;
               // 16 bits in and SCLK already high: the 32nd half-period just ended.
               if (bit_cnt == 5'd16 && J_MIC_SCLK) begin
                  state_nx = DONE;
               end else begin
                  sclk_nx = ~J_MIC_SCLK;
                  if (!J_MIC_SCLK) begin
                     shift_nx   = {shift[14:0], J_MIC_MISO};
                     bit_cnt_nx = bit_cnt + 5'd1;
                  end
               end
            end else begin
               hcnt_nx = hcnt + HCW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            cs_n_nx  = 1'b1;
            sclk_nx  = 1'b1;
            valid_nx = 1'b1;
            raw_nx   = shift[11:0];
            wave_nx  = shift[11:2];
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         hcnt         <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         J_MIC_CS_N   <= 1'b1;
         J_MIC_SCLK   <= 1'b1;
         sample_valid <= 1'b0;
         raw_sample   <= '0;
         wave_sample  <= '0;
      end else begin
         state        <= state_nx;
         hcnt         <= hcnt_nx;
         bit_cnt      <= bit_cnt_nx;
         shift        <= shift_nx;
         J_MIC_CS_N   <= cs_n_nx;
         J_MIC_SCLK   <= sclk_nx;
         sample_valid <= valid_nx;
         raw_sample   <= raw_nx;
         wave_sample  <= wave_nx;
      end
   end

endmodule
